fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter MAX_LOG2N, default 12, giving the largest FFT size exponent supported (4096 points).
REQ-002 SHALL have parameter MIN_LOG2N, default 3, giving the smallest supported exponent.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 64, giving the maximum cycles allowed in FLUSH_PIPE per level.
REQ-004 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: fft_go  input  1  frame start request, sampled in IDLE.
REQ-007 SHALL have port: cfg_log2n  input  LW=$clog2(MAX_LOG2N+1)  requested size exponent, latched on accepted fft_go.
REQ-008 SHALL have port: cfg_inverse  input  1  inverse-FFT select, latched on accepted fft_go.
REQ-009 SHALL have port: cfg_continuous  input  1  after AXIS_SEND completes, start the next frame without fft_go; sampled live.
REQ-010 SHALL have port: abort  input  1  terminate the current frame.
REQ-011 SHALL have port: axis_bram_slave_busy  input  1  input stream loader busy.
REQ-012 SHALL have port: axis_bram_slave_go  output  1  loader start pulse.
REQ-013 SHALL have port: addr_gen_busy  input  1  address generator busy for the current level.
REQ-014 SHALL have port: addr_gen_go  output  1  level start pulse.
REQ-015 SHALL have port: fft_data_valid  input  1  butterfly pipeline holds valid data.
REQ-016 SHALL have port: axis_bram_master_busy  input  1  output streamer busy.
REQ-017 SHALL have port: axis_bram_master_go  output  1  streamer start pulse.
REQ-018 SHALL have port: fft_level  output  $clog2(MAX_LOG2N)  current level index.
REQ-019 SHALL have port: fft_inverse  output  1  latched cfg_inverse, to twiddle conjugation and output scaling.
REQ-020 SHALL have port: rmem_id / wmem_id  output  1 each  read bank = fft_level[0], write bank = ~fft_level[0].
REQ-021 SHALL have port: result_mem_id  output  1  bank holding the final result, = latched log2n[0].
REQ-022 SHALL have port: axis_rx / axis_tx / fft_busy  output  1 each  state==AXIS_READ / state==AXIS_SEND / state!=IDLE.
REQ-023 SHALL have port: frame_done  output  1  one-cycle pulse when AXIS_SEND completes normally.
REQ-024 SHALL have port: err  output  2  sticky error code: 0 none, 1 bad size, 2 flush timeout, 3 aborted.

Function
REQ-025 States SHALL be IDLE, AXIS_READ, COMPUTE, FLUSH_PIPE, AXIS_SEND and ERROR, in a 3-bit registered encoding.
REQ-026 In IDLE, fft_go with MIN_LOG2N<=cfg_log2n<=MAX_LOG2N SHALL latch the configuration, clear err and fft_level, pulse axis_bram_slave_go in the same cycle (combinational) and go to AXIS_READ; an out-of-range cfg_log2n SHALL set err=1, go to ERROR and issue no go pulses.
REQ-027 AXIS_READ SHALL be left when axis_bram_slave_busy=0, pulsing addr_gen_go that cycle and going to COMPUTE.
REQ-028 COMPUTE SHALL hold while addr_gen_busy=1, then go to FLUSH_PIPE with the flush counter cleared.
REQ-029 In FLUSH_PIPE with fft_data_valid=0: if fft_level==log2n-1, SHALL pulse axis_bram_master_go and go to AXIS_SEND; otherwise SHALL increment fft_level, pulse addr_gen_go and go to COMPUTE.
REQ-030 In FLUSH_PIPE, if fft_data_valid stays 1 for FLUSH_TIMEOUT consecutive cycles, SHALL set err=2 and go to ERROR.
REQ-031 AXIS_SEND SHALL be left when axis_bram_master_busy=0, pulsing frame_done; if cfg_continuous=1, SHALL go to AXIS_READ with an axis_bram_slave_go pulse, fft_level=0 and the previous configuration kept; otherwise SHALL go to IDLE.
REQ-032 abort=1 in any state except IDLE or ERROR SHALL set err=3 and go to ERROR next cycle, taking priority over every other transition that cycle; no go pulse SHALL be issued in that cycle.
REQ-033 ERROR SHALL go to IDLE on fft_go (err is retained until the next accepted start); fft_busy SHALL be 1 in ERROR.
REQ-034 Each go output SHALL be high for at most one cycle per transition and SHALL never be asserted while its own busy input is 1.

Reset
REQ-035 reset SHALL force state IDLE, fft_level 0, err 0, fft_inverse 0, latched log2n MAX_LOG2N, flush counter 0 and all go pulses and frame_done 0, overriding abort and fft_go.
REQ-036 reset asserted mid-frame SHALL take effect on the next clk edge, with no go pulse in the reset cycle.

Structure
REQ-037 State encodings, err codes and the LW/level-width constants SHALL live in shared package fft_defs, replacing the fixed LEVELS define.
REQ-038 The flush timeout SHALL be a separate sub-module, fft_flush_timer (clear, enable, expired).

Verification
REQ-039 cfg_log2n=3, fft_go, stub busies of 4 cycles -> 3 addr_gen_go pulses, fft_level 0,1,2, rmem_id 0,1,0, result_mem_id=1, one frame_done.
REQ-040 cfg_log2n=12, cfg_inverse=1 -> 12 levels, fft_inverse=1 throughout, axis_bram_master_go exactly once after level 11.
REQ-041 cfg_log2n=2 or 13 with fft_go -> err=1, ERROR, no go pulses; the next fft_go with log2n=4 runs normally with err=0.
REQ-042 fft_data_valid held at 1 in FLUSH_PIPE -> err=2 exactly 64 cycles after entry; abort during COMPUTE -> err=3 the next cycle.
REQ-043 cfg_continuous=1 for 3 frames -> 3 frame_done pulses, axis_bram_slave_go in the same cycle as each of the first two frame_done pulses, no IDLE between frames.
REQ-044 reset asserted in COMPUTE at level 5 -> IDLE, fft_level=0 and all outputs at their reset values on the next cycle.

Source files
------------

// File: rtl/fft_defs.sv
// Shared definitions for the FFT frame controller: default sizes,
// derived width helpers, state encoding and error codes.
package fft_defs;

  localparam int unsigned MAX_LOG2N_DEF     = 12;
  localparam int unsigned MIN_LOG2N_DEF     = 3;
  localparam int unsigned FLUSH_TIMEOUT_DEF = 64;

  // Width of a size exponent able to hold 0..max_log2n.
  function automatic int unsigned lw_of(input int unsigned max_log2n);
    return $clog2(max_log2n + 1);
  endfunction

  // Width of a level index holding 0..max_log2n-1.
  function automatic int unsigned level_w_of(input int unsigned max_log2n);
    return (max_log2n > 1) ? $clog2(max_log2n) : 1;
  endfunction

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    AXIS_READ  = 3'd1,
    COMPUTE    = 3'd2,
    FLUSH_PIPE = 3'd3,
    AXIS_SEND  = 3'd4,
    ERROR      = 3'd5
  } fft_state_e;

  typedef enum logic [1:0] {
    ERR_NONE          = 2'd0,
    ERR_BAD_SIZE      = 2'd1,
    ERR_FLUSH_TIMEOUT = 2'd2,
    ERR_ABORTED       = 2'd3
  } fft_err_e;

endpackage

// File: rtl/fft_flush_timer.sv
// Counts consecutive enabled cycles; expired is raised combinationally
// during the TIMEOUT-th consecutive enabled cycle since the last clear.
module fft_flush_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear wins, then advance while enabled and not yet expired.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for an in-place radix-2 FFT: load, per-level compute and
// pipeline flush, then stream out, with optional back-to-back frames.
//
// state      | meaning
// IDLE       | waiting for fft_go
// AXIS_READ  | input loader filling memory
// COMPUTE    | address generator running one level
// FLUSH_PIPE | waiting for the butterfly pipeline to drain
// AXIS_SEND  | output streamer draining the result bank
// ERROR      | sticky error, leave on fft_go
module fft_frame_ctrl
  import fft_defs::*;
#(
  parameter int unsigned MAX_LOG2N     = MAX_LOG2N_DEF,
  parameter int unsigned MIN_LOG2N     = MIN_LOG2N_DEF,
  parameter int unsigned FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
  localparam int unsigned LW           = lw_of(MAX_LOG2N),
  localparam int unsigned LEVEL_W      = level_w_of(MAX_LOG2N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fft_go,
  input  logic [LW-1:0]      cfg_log2n,
  input  logic               cfg_inverse,
  input  logic               cfg_continuous,
  input  logic               abort,
  input  logic               axis_bram_slave_busy,
  output logic               axis_bram_slave_go,
  input  logic               addr_gen_busy,
  output logic               addr_gen_go,
  input  logic               fft_data_valid,
  input  logic               axis_bram_master_busy,
  output logic               axis_bram_master_go,
  output logic [LEVEL_W-1:0] fft_level,
  output logic               fft_inverse,
  output logic               rmem_id,
  output logic               wmem_id,
  output logic               result_mem_id,
  output logic               axis_rx,
  output logic               axis_tx,
  output logic               fft_busy,
  output logic               frame_done,
  output logic [1:0]         err
);

  fft_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] fft_level_q, fft_level_d;
  logic [LW-1:0]      log2n_q, log2n_d;
  logic               inverse_q, inverse_d;
  fft_err_e           err_q, err_d;

  logic slave_go_c, ag_go_c, master_go_c, done_c;
  logic timer_clear, timer_en, timer_expired;
  logic size_ok, last_level, abort_hit;

  fft_flush_timer #(
    .TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  assign size_ok    = (cfg_log2n >= LW'(MIN_LOG2N)) && (cfg_log2n <= LW'(MAX_LOG2N));
  assign last_level = (LW'(fft_level_q) == (log2n_q - LW'(1)));
  assign abort_hit  = abort && (state_q != IDLE) && (state_q != ERROR);

  // Next-state and pulse decode; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    fft_level_d = fft_level_q;
    log2n_d     = log2n_q;
    inverse_d   = inverse_q;
    err_d       = err_q;
    slave_go_c  = 1'b0;
    ag_go_c     = 1'b0;
    master_go_c = 1'b0;
    done_c      = 1'b0;
    timer_clear = 1'b1;
    timer_en    = 1'b0;

    if (abort_hit) begin
      state_d = ERROR;
      err_d   = ERR_ABORTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (fft_go) begin
            if (!size_ok) begin
              err_d   = ERR_BAD_SIZE;
              state_d = ERROR;
            end else if (!axis_bram_slave_busy) begin
              log2n_d     = cfg_log2n;
              inverse_d   = cfg_inverse;
              err_d       = ERR_NONE;
              fft_level_d = '0;
              slave_go_c  = 1'b1;
              state_d     = AXIS_READ;
            end
          end
        end

        AXIS_READ: begin
          if (!axis_bram_slave_busy && !addr_gen_busy) begin
            ag_go_c = 1'b1;
            state_d = COMPUTE;
          end
        end

        COMPUTE: begin
          if (!addr_gen_busy) begin
            state_d = FLUSH_PIPE;
          end
        end

        FLUSH_PIPE: begin
          // Any cycle with the pipeline empty breaks the consecutive run.
          timer_clear = !fft_data_valid;
          timer_en    = fft_data_valid;
          if (!fft_data_valid) begin
            if (last_level) begin
              if (!axis_bram_master_busy) begin
                master_go_c = 1'b1;
                state_d     = AXIS_SEND;
              end
            end else if (!addr_gen_busy) begin
              fft_level_d = fft_level_q + LEVEL_W'(1);
              ag_go_c     = 1'b1;
              state_d     = COMPUTE;
            end
          end else if (timer_expired) begin
            err_d   = ERR_FLUSH_TIMEOUT;
            state_d = ERROR;
          end
        end

        AXIS_SEND: begin
          if (!axis_bram_master_busy) begin
            if (cfg_continuous) begin
              // Hold off completion until the loader can take the restart.
              if (!axis_bram_slave_busy) begin
                done_c      = 1'b1;
                slave_go_c  = 1'b1;
                fft_level_d = '0;
                state_d     = AXIS_READ;
              end
            end else begin
              done_c  = 1'b1;
              state_d = IDLE;
            end
          end
        end

        ERROR: begin
          if (fft_go) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fft_level_q <= '0;
      log2n_q     <= LW'(MAX_LOG2N);
      inverse_q   <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      fft_level_q <= fft_level_d;
      log2n_q     <= log2n_d;
      inverse_q   <= inverse_d;
      err_q       <= err_d;
    end
  end

  // Pulses are combinational and suppressed while reset is asserted.
  assign axis_bram_slave_go  = slave_go_c  && !reset;
  assign addr_gen_go         = ag_go_c     && !reset;
  assign axis_bram_master_go = master_go_c && !reset;
  assign frame_done          = done_c      && !reset;

  assign fft_level     = fft_level_q;
  assign fft_inverse   = inverse_q;
  assign rmem_id       = fft_level_q[0];
  assign wmem_id       = ~fft_level_q[0];
  assign result_mem_id = log2n_q[0];
  assign axis_rx       = (state_q == AXIS_READ);
  assign axis_tx       = (state_q == AXIS_SEND);
  assign fft_busy      = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: busy stubs, a go-pulse scoreboard, a table of
// frame configurations, and hand-written flush/abort/continuous/reset cases.
module tb_fft_frame_ctrl;

  localparam int K_SLV  = 1;
  localparam int K_AG   = 2;
  localparam int K_MST  = 3;
  localparam int K_DONE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fft_go = 1'b0;
  logic [3:0] cfg_log2n = 4'd0;
  logic       cfg_inverse = 1'b0;
  logic       cfg_continuous = 1'b0;
  logic       abort = 1'b0;
  logic       axis_bram_slave_busy;
  logic       axis_bram_slave_go;
  logic       addr_gen_busy;
  logic       addr_gen_go;
  logic       fft_data_valid = 1'b0;
  logic       axis_bram_master_busy;
  logic       axis_bram_master_go;
  logic [3:0] fft_level;
  logic       fft_inverse, rmem_id, wmem_id, result_mem_id;
  logic       axis_rx, axis_tx, fft_busy, frame_done;
  logic [1:0] err;

  fft_frame_ctrl dut (
    .clk                   (clk),
    .reset                 (reset),
    .fft_go                (fft_go),
    .cfg_log2n             (cfg_log2n),
    .cfg_inverse           (cfg_inverse),
    .cfg_continuous        (cfg_continuous),
    .abort                 (abort),
    .axis_bram_slave_busy  (axis_bram_slave_busy),
    .axis_bram_slave_go    (axis_bram_slave_go),
    .addr_gen_busy         (addr_gen_busy),
    .addr_gen_go           (addr_gen_go),
    .fft_data_valid        (fft_data_valid),
    .axis_bram_master_busy (axis_bram_master_busy),
    .axis_bram_master_go   (axis_bram_master_go),
    .fft_level             (fft_level),
    .fft_inverse           (fft_inverse),
    .rmem_id               (rmem_id),
    .wmem_id               (wmem_id),
    .result_mem_id         (result_mem_id),
    .axis_rx               (axis_rx),
    .axis_tx               (axis_tx),
    .fft_busy              (fft_busy),
    .frame_done            (frame_done),
    .err                   (err)
  );

  always #5 clk = ~clk;

  // Busy stubs: each goes busy for 4 cycles starting the cycle after its go.
  logic [2:0] sb_cnt, ag_cnt, mb_cnt;
  always @(posedge clk) begin
    if (reset) begin
      sb_cnt <= 3'd0;
      ag_cnt <= 3'd0;
      mb_cnt <= 3'd0;
    end else begin
      sb_cnt <= axis_bram_slave_go  ? 3'd4 : (sb_cnt != 3'd0 ? sb_cnt - 3'd1 : 3'd0);
      ag_cnt <= addr_gen_go         ? 3'd4 : (ag_cnt != 3'd0 ? ag_cnt - 3'd1 : 3'd0);
      mb_cnt <= axis_bram_master_go ? 3'd4 : (mb_cnt != 3'd0 ? mb_cnt - 3'd1 : 3'd0);
    end
  end
  assign axis_bram_slave_busy  = (sb_cnt != 3'd0);
  assign addr_gen_busy         = (ag_cnt != 3'd0);
  assign axis_bram_master_busy = (mb_cnt != 3'd0);

  int total = 0;
  int bad = 0;
  int exp_q[$];
  bit pend_ag = 1'b0;
  int done_cnt = 0;
  bit watch_cont = 1'b0;
  bit idle_seen = 1'b0;

  typedef struct {
    logic [3:0] log2n;
    logic       inv;
    logic [1:0] exp_err;
  } vec_t;
  vec_t vecs[9];

  function automatic int ev(int kind, int lvl, int rmem, int inv);
    return (kind << 8) | (lvl << 2) | ((rmem & 1) << 1) | (inv & 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic sb_pop(string name, int act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got event %0d expected no event at %0t", name, act, $time);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic push_frame(int n, int inv);
    exp_q.push_back(ev(K_SLV, 0, 0, 0));
    for (int l = 0; l < n; l++) exp_q.push_back(ev(K_AG, l, l & 1, inv));
    exp_q.push_back(ev(K_MST, n - 1, (n - 1) & 1, inv));
    exp_q.push_back(ev(K_DONE, 0, 0, 0));
  endtask

  task automatic monitor();
    if (pend_ag) begin
      pend_ag = 1'b0;
      sb_pop("ag_level", ev(K_AG, int'(fft_level), int'(rmem_id), int'(fft_inverse)));
    end
    if (frame_done) begin
      done_cnt++;
      sb_pop("frame_done", ev(K_DONE, 0, 0, 0));
      check("done_with_slave_go", axis_bram_slave_go, cfg_continuous);
    end
    if (axis_bram_slave_go) begin
      check("slave_go_while_busy", axis_bram_slave_busy, 0);
      sb_pop("slave_go", ev(K_SLV, 0, 0, 0));
    end
    if (addr_gen_go) begin
      check("ag_go_while_busy", addr_gen_busy, 0);
      pend_ag = 1'b1;
    end
    if (axis_bram_master_go) begin
      check("master_go_while_busy", axis_bram_master_busy, 0);
      sb_pop("master_go", ev(K_MST, int'(fft_level), int'(rmem_id), int'(fft_inverse)));
    end
    if (watch_cont && !fft_busy) idle_seen = 1'b1;
  endtask

  // Inputs change at posedge+1; outputs are sampled at the negedge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic start(logic [3:0] n, logic inv);
    cfg_log2n   = n;
    cfg_inverse = inv;
    fft_go      = 1'b1;
    step();
    fft_go      = 1'b0;
  endtask

  task automatic leave_error();
    fft_go = 1'b1;
    step();
    fft_go = 1'b0;
    step();
  endtask

  initial begin
    int n;
    vecs[0] = '{4'd3,  1'b0, 2'd0};
    vecs[1] = '{4'd2,  1'b0, 2'd1};
    vecs[2] = '{4'd4,  1'b1, 2'd0};
    vecs[3] = '{4'd13, 1'b0, 2'd1};
    vecs[4] = '{4'd12, 1'b1, 2'd0};
    vecs[5] = '{4'd0,  1'b1, 2'd1};
    vecs[6] = '{4'd5,  1'b0, 2'd0};
    vecs[7] = '{4'd15, 1'b0, 2'd1};
    vecs[8] = '{4'd9,  1'b1, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", fft_busy, 0);
    check("rst_err", err, 0);
    check("rst_level", fft_level, 0);
    check("rst_inverse", fft_inverse, 0);
    check("rst_result_mem", result_mem_id, 0);
    check("rst_wmem", wmem_id, 1);
    check("rst_gos", {axis_bram_slave_go, addr_gen_go, axis_bram_master_go, frame_done}, 0);

    // Table of frame configurations.
    foreach (vecs[i]) begin
      done_cnt = 0;
      if (vecs[i].exp_err == 2'd0) push_frame(int'(vecs[i].log2n), int'(vecs[i].inv));
      start(vecs[i].log2n, vecs[i].inv);
      if (vecs[i].exp_err != 2'd0) begin
        check("bad_size_err", err, vecs[i].exp_err);
        check("bad_size_in_error_busy", fft_busy, 1);
        leave_error();
        check("error_exit_idle", fft_busy, 0);
        check("error_err_retained", err, vecs[i].exp_err);
      end else begin
        n = 0;
        while (done_cnt == 0 && n < 2000) begin step(); n++; end
        check("frame_done_count", done_cnt, 1);
        step();
        check("frame_idle", fft_busy, 0);
        check("frame_err", err, 0);
        check("frame_result_mem", result_mem_id, vecs[i].log2n[0]);
        check("frame_inverse", fft_inverse, vecs[i].inv);
      end
      check("sb_empty", exp_q.size(), 0);
    end

    // Flush timeout: err=2 exactly 64 cycles after entering FLUSH_PIPE.
    exp_q.push_back(ev(K_SLV, 0, 0, 0));
    exp_q.push_back(ev(K_AG, 0, 0, 0));
    fft_data_valid = 1'b1;
    start(4'd3, 1'b0);
    n = 0;
    while (!addr_gen_busy && n < 50) begin step(); n++; end
    check("flush_reach_compute", addr_gen_busy, 1);
    n = 0;
    while (addr_gen_busy && n < 50) begin step(); n++; end
    check("flush_compute_done", addr_gen_busy, 0);
    for (int k = 0; k < 64; k++) step();
    check("flush_err_before_limit", err, 0);
    step();
    check("flush_err_at_limit", err, 2);
    check("flush_err_busy", fft_busy, 1);
    fft_data_valid = 1'b0;
    leave_error();
    check("flush_sb_empty", exp_q.size(), 0);

    // Abort during COMPUTE.
    exp_q.push_back(ev(K_SLV, 0, 0, 0));
    exp_q.push_back(ev(K_AG, 0, 0, 0));
    start(4'd4, 1'b0);
    n = 0;
    while (!addr_gen_busy && n < 50) begin step(); n++; end
    check("abort_reach_compute", addr_gen_busy, 1);
    abort = 1'b1;
    #1;
    check("abort_no_go", {axis_bram_slave_go, addr_gen_go, axis_bram_master_go, frame_done}, 0);
    step();
    abort = 1'b0;
    check("abort_err", err, 3);
    check("abort_busy", fft_busy, 1);
    leave_error();
    check("abort_sb_empty", exp_q.size(), 0);

    // Continuous mode: three frames without returning to IDLE.
    done_cnt = 0;
    idle_seen = 1'b0;
    push_frame(3, 0);
    push_frame(3, 0);
    push_frame(3, 0);
    cfg_continuous = 1'b1;
    start(4'd3, 1'b0);
    watch_cont = 1'b1;
    n = 0;
    while (done_cnt < 2 && n < 2000) begin step(); n++; end
    cfg_continuous = 1'b0;
    while (done_cnt < 3 && n < 4000) begin step(); n++; end
    watch_cont = 1'b0;
    check("cont_done_count", done_cnt, 3);
    check("cont_no_idle", idle_seen, 0);
    step();
    check("cont_final_idle", fft_busy, 0);
    check("cont_sb_empty", exp_q.size(), 0);

    // Reset while computing level 5.
    push_frame(7, 1);
    start(4'd7, 1'b1);
    n = 0;
    while (!(fft_level == 4'd5 && addr_gen_busy) && n < 2000) begin step(); n++; end
    check("rst_reach_level5", fft_level, 5);
    check("rst_pre_result_mem", result_mem_id, 1);
    reset = 1'b1;
    abort = 1'b1;
    fft_go = 1'b1;
    #1;
    check("rst_cycle_no_go", {axis_bram_slave_go, addr_gen_go, axis_bram_master_go, frame_done}, 0);
    step();
    reset = 1'b0;
    abort = 1'b0;
    fft_go = 1'b0;
    pend_ag = 1'b0;
    exp_q.delete();
    check("mid_rst_level", fft_level, 0);
    check("mid_rst_busy", fft_busy, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_inverse", fft_inverse, 0);
    check("mid_rst_result_mem", result_mem_id, 0);
    check("mid_rst_rx_tx", {axis_rx, axis_tx}, 0);
    check("mid_rst_gos", {axis_bram_slave_go, addr_gen_go, axis_bram_master_go, frame_done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
